sseg_scan_decoder: RTL and testbench
====================================

SSEG_SCAN_DECODER -- requirements
Module: sseg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 16: consecutive identical input samples required before a digit is captured; legal range 2..255.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 anodes  input  4  active-low digit enables from a multiplexed display driver; bit i selects slot i.
REQ-005 cathodes  input  8  active-low segments; bit7 = dp, bits6..0 = g,f,e,d,c,b,a.
REQ-006 digits_out  output  16  last complete frame; slot i occupies bits 4i+3..4i.
REQ-007 dp_out  output  4  last complete frame decimal points, active-high, bit i = slot i.
REQ-008 frame_valid  output  1  one-cycle pulse when digits_out/dp_out update.
REQ-009 code_err  output  1  one-cycle pulse when a stable pattern fails to decode.

Function
REQ-010 The block SHALL register anodes and cathodes once; all decisions use the registered copies, and the previous registered copy is kept for change detection.
REQ-011 The block SHALL decode cathodes[6:0] to hex as: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0100000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-012 Any other 7-bit pattern, including blank 1111111, SHALL be undecodable.
REQ-013 FSM states: WAIT, SETTLE, HOLD.
REQ-014 WAIT: when the registered anodes have exactly one bit low, go to SETTLE with the stability counter at 1.
REQ-015 SETTLE: each cycle with registered anodes and cathodes unchanged from the previous cycle increments the counter; any change restarts the count at 1, staying in SETTLE if the anodes are still one-cold, otherwise going to WAIT.
REQ-016 When the counter reaches STABLE_CYCLES, the block SHALL capture on that edge and go to HOLD.
REQ-017 Capture of a decodable pattern: store the nibble and the inverted cathodes[7] into the slot buffer, and set the slot's bit in the 4-bit captured mask.
REQ-018 Capture of an undecodable pattern: pulse code_err for one cycle; leave the slot buffer and the mask unchanged.
REQ-019 HOLD: no further capture; any change in the registered anodes or cathodes returns to WAIT, evaluated on the same edge.
REQ-020 Zero or two-plus anodes low, in any state, SHALL force WAIT and clear the counter.
REQ-021 When the mask becomes 1111, on the next edge the block SHALL copy the buffers to digits_out/dp_out, pulse frame_valid, and clear the mask.
REQ-022 A capture coinciding with the frame-complete edge SHALL set its bit in the freshly cleared mask (the new capture is not lost).
REQ-023 Recapturing a slot already in the mask SHALL overwrite its buffer without affecting other bits.
REQ-024 The counter SHALL saturate at STABLE_CYCLES and never wrap.

Reset
REQ-025 Asserting reset SHALL immediately set: FSM = WAIT, counter = 0, mask = 0, buffers = 0, digits_out = 16'h0000, dp_out = 4'b0000, frame_valid = 0, code_err = 0, and input registers = all ones (idle).
REQ-026 Reset asserted mid-SETTLE or mid-frame SHALL discard partial captures; the first frame_valid after release requires four fresh captures.

Configuration
REQ-027 Macro SSEG_DP_CAPTURE_EN: when defined, dp is captured per REQ-017, and a dp-only change counts as a change for REQ-015/REQ-019.
REQ-028 Without SSEG_DP_CAPTURE_EN: dp_out SHALL be held at 4'b0000, and cathodes[7] SHALL be ignored for both decoding and change detection.

Verification
REQ-029 Scan slots 0..3 with cathodes 1111001, 0100100, 0110000, 0011001 (dp off), 20 cycles each -> one frame_valid, digits_out = 16'h4321, code_err never asserted.
REQ-030 Slot 2 held for only 10 cycles (STABLE_CYCLES=16), the rest for 20 -> no frame_valid until slot 2 is held for at least 16 cycles.
REQ-031 Slot 1 shows the undecodable pattern 1111111 for 20 cycles -> exactly one code_err pulse; mask bit 1 stays clear; no frame_valid.
REQ-032 anodes = 4'b1100 for 30 cycles -> FSM stays in WAIT, no capture, no code_err.
REQ-033 Reset asserted after three slots are captured, then a full scan of 8,9,A,b -> first frame_valid gives digits_out = 16'hBA98.
REQ-034 With SSEG_DP_CAPTURE_EN defined, scanning 0 on all slots with dp low on slot 3 -> dp_out = 4'b1000; without the macro, the same scan gives dp_out = 4'b0000.

Source files
------------

// File: rtl/sseg_scan_decoder_if.sv
// Interface for sseg_scan_decoder: display-bus inputs plus the decoded frame outputs.
interface sseg_scan_decoder_if;
    logic [3:0]  anodes;
    logic [7:0]  cathodes;
    logic [15:0] digits_out;
    logic [3:0]  dp_out;
    logic        frame_valid;
    logic        code_err;

    modport master (
        output anodes, cathodes,
        input  digits_out, dp_out, frame_valid, code_err
    );

    modport slave (
        input  anodes, cathodes,
        output digits_out, dp_out, frame_valid, code_err
    );
endinterface

// File: rtl/sseg_scan_decoder.sv
// Recovers hex digits from a multiplexed 7-segment scan bus and publishes complete 4-digit frames.
// Optional macro SSEG_DP_CAPTURE_EN enables decimal-point capture and dp-sensitive change detection.
module sseg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input logic           clk,
    input logic           reset,
    sseg_scan_decoder_if.slave bus
);
    typedef enum logic [1:0] {WAIT, SETTLE, HOLD} state_t;

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
`ifdef SSEG_DP_CAPTURE_EN
    localparam logic [7:0] CHG_MASK = 8'hFF;
`else
    localparam logic [7:0] CHG_MASK = 8'h7F;
`endif

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [3:0]  an_r, an_p;
    logic [7:0]  ca_r, ca_p;
    logic [3:0]  mask, mask_nxt;
    logic [15:0] dig_buf;
    logic [3:0]  dp_buf;
    logic [15:0] digits_q;
    logic [3:0]  dp_q;
    logic        fv_q, err_q;

    logic        one_cold;
    logic [1:0]  slot;
    logic        changed;
    logic [3:0]  nib;
    logic        dec_ok;
    logic        capture;
    logic        cap_dp;

    assign changed = (an_r != an_p) || ((ca_r & CHG_MASK) != (ca_p & CHG_MASK));

`ifdef SSEG_DP_CAPTURE_EN
    assign cap_dp = ~ca_r[7];
`else
    assign cap_dp = 1'b0;
`endif

    always_comb begin
        one_cold = 1'b1;
        slot     = '0;
        case (an_r)
            4'b1110: slot = 2'd0;
            4'b1101: slot = 2'd1;
            4'b1011: slot = 2'd2;
            4'b0111: slot = 2'd3;
            default: one_cold = 1'b0;
        endcase
    end

    always_comb begin
        nib    = '0;
        dec_ok = 1'b1;
        case (ca_r[6:0])
            7'b1000000: nib = 4'h0;
            7'b1111001: nib = 4'h1;
            7'b0100100: nib = 4'h2;
            7'b0110000: nib = 4'h3;
            7'b0011001: nib = 4'h4;
            7'b0010010: nib = 4'h5;
            7'b0000010: nib = 4'h6;
            7'b1111000: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0010000: nib = 4'h9;
            7'b0100000: nib = 4'hA;
            7'b0000011: nib = 4'hB;
            7'b1000110: nib = 4'hC;
            7'b0100001: nib = 4'hD;
            7'b0000110: nib = 4'hE;
            7'b0001110: nib = 4'hF;
            default:    dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        if (!one_cold) begin
            state_nxt = WAIT;
            cnt_nxt   = '0;
        end else begin
            case (state)
                WAIT: begin
                    state_nxt = SETTLE;
                    cnt_nxt   = 8'd1;
                end
                SETTLE: begin
                    if (changed) begin
                        cnt_nxt = 8'd1;
                    end else if (cnt + 8'd1 >= STABLE) begin
                        cnt_nxt   = STABLE;
                        capture   = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (changed) begin
                        state_nxt = WAIT;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = WAIT;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // A capture on the frame-complete edge lands in the freshly cleared mask.
    always_comb begin
        mask_nxt = (mask == 4'hF) ? '0 : mask;
        if (capture && dec_ok)
            mask_nxt[slot] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WAIT;
            cnt   <= '0;
            an_r  <= '1;
            an_p  <= '1;
            ca_r  <= '1;
            ca_p  <= '1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            an_r  <= bus.anodes;
            an_p  <= an_r;
            ca_r  <= bus.cathodes;
            ca_p  <= ca_r;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask     <= '0;
            dig_buf  <= '0;
            dp_buf   <= '0;
            digits_q <= '0;
            dp_q     <= '0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            mask  <= mask_nxt;
            fv_q  <= (mask == 4'hF);
            err_q <= capture && !dec_ok;
            if (mask == 4'hF) begin
                digits_q <= dig_buf;
                dp_q     <= dp_buf;
            end
            if (capture && dec_ok) begin
                dig_buf[{slot, 2'b00} +: 4] <= nib;
                dp_buf[slot]                <= cap_dp;
            end
        end
    end

    assign bus.digits_out  = digits_q;
    assign bus.dp_out      = dp_q;
    assign bus.frame_valid = fv_q;
    assign bus.code_err    = err_q;
endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Self-checking bench for sseg_scan_decoder: directed scans plus randomized segment sequences vs a frame-level model.
module tb_sseg_scan_decoder;
    localparam int unsigned STABLE = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sseg_scan_decoder_if bif();

    sseg_scan_decoder #(.STABLE_CYCLES(STABLE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    logic [6:0] segtab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0100000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    logic [19:0] obs_q[$];
    int          err_total = 0;

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bif.frame_valid === 1'b1) obs_q.push_back({bif.dp_out, bif.digits_out});
            if (bif.code_err === 1'b1) err_total++;
        end
    end

    function automatic logic [7:0] pat(input int d, input bit dp_on);
        logic [6:0] s;
        s = segtab[d];
        return {~dp_on, s};
    endfunction

    // Entered and left on a falling edge; holds the pattern for exactly n cycles.
    task automatic drive(input logic [3:0] an, input logic [7:0] ca, input int n);
        bif.anodes   = an;
        bif.cathodes = ca;
        repeat (n) @(negedge clk);
    endtask

    task automatic slot_drive(input int s, input logic [7:0] ca, input int n);
        logic [3:0] one;
        one = 4'b0001 << s;
        drive(~one, ca, n);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bif.anodes   = 4'hF;
        bif.cathodes = 8'hFF;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bif.anodes   = 4'hF;
        bif.cathodes = 8'hFF;
        @(negedge clk);
        checks++; if (bif.digits_out !== 16'h0000) begin errors++; $display("FAIL reset_digits got %h want 0000", bif.digits_out); end
        checks++; if (bif.dp_out !== 4'h0) begin errors++; $display("FAIL reset_dp got %b want 0000", bif.dp_out); end
        checks++; if (bif.frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got %b want 0", bif.frame_valid); end
        checks++; if (bif.code_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bif.code_err); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int bf, be;
        do_reset();
        bf = obs_q.size(); be = err_total;
        for (int s = 0; s < 4; s++) slot_drive(s, pat(s + 1, 1'b0), 20);
        drive(4'hF, 8'hFF, 5);
        checks++; if (obs_q.size() - bf !== 1) begin errors++; $display("FAIL basic_frames got %0d want 1", obs_q.size() - bf); end
        else begin
            checks++; if (obs_q[bf][15:0] !== 16'h4321) begin errors++; $display("FAIL basic_digits got %h want 4321", obs_q[bf][15:0]); end
            checks++; if (obs_q[bf][19:16] !== 4'h0) begin errors++; $display("FAIL basic_dp got %b want 0000", obs_q[bf][19:16]); end
        end
        checks++; if (err_total - be !== 0) begin errors++; $display("FAIL basic_code_err got %0d want 0", err_total - be); end
    endtask

    task automatic test_short_slot();
        int bf;
        do_reset();
        bf = obs_q.size();
        slot_drive(0, pat(1, 1'b0), 20);
        slot_drive(1, pat(2, 1'b0), 20);
        slot_drive(2, pat(3, 1'b0), 10);
        slot_drive(3, pat(4, 1'b0), 20);
        drive(4'hF, 8'hFF, 3);
        checks++; if (obs_q.size() - bf !== 0) begin errors++; $display("FAIL short_noframe got %0d want 0", obs_q.size() - bf); end
        slot_drive(2, pat(3, 1'b0), 20);
        drive(4'hF, 8'hFF, 3);
        checks++; if (obs_q.size() - bf !== 1) begin errors++; $display("FAIL short_frame got %0d want 1", obs_q.size() - bf); end
        else begin
            checks++; if (obs_q[bf][15:0] !== 16'h4321) begin errors++; $display("FAIL short_digits got %h want 4321", obs_q[bf][15:0]); end
        end
    endtask

    task automatic test_code_err();
        int bf, be;
        do_reset();
        bf = obs_q.size(); be = err_total;
        slot_drive(0, pat(1, 1'b0), 20);
        slot_drive(1, 8'hFF, 20);
        slot_drive(2, pat(3, 1'b0), 20);
        slot_drive(3, pat(4, 1'b0), 20);
        drive(4'hF, 8'hFF, 3);
        checks++; if (err_total - be !== 1) begin errors++; $display("FAIL codeerr_count got %0d want 1", err_total - be); end
        checks++; if (obs_q.size() - bf !== 0) begin errors++; $display("FAIL codeerr_noframe got %0d want 0", obs_q.size() - bf); end
        slot_drive(1, pat(2, 1'b0), 20);
        drive(4'hF, 8'hFF, 3);
        checks++; if (obs_q.size() - bf !== 1) begin errors++; $display("FAIL codeerr_frame got %0d want 1", obs_q.size() - bf); end
        else begin
            checks++; if (obs_q[bf][15:0] !== 16'h4321) begin errors++; $display("FAIL codeerr_digits got %h want 4321", obs_q[bf][15:0]); end
        end
    endtask

    task automatic test_multi_anode();
        int bf, be;
        do_reset();
        bf = obs_q.size(); be = err_total;
        drive(4'b1100, 8'hFF, 30);
        drive(4'hF, 8'hFF, 3);
        checks++; if (err_total - be !== 0) begin errors++; $display("FAIL multi_code_err got %0d want 0", err_total - be); end
        checks++; if (obs_q.size() - bf !== 0) begin errors++; $display("FAIL multi_frames got %0d want 0", obs_q.size() - bf); end
    endtask

    task automatic test_reset_mid();
        int bf;
        do_reset();
        bf = obs_q.size();
        for (int s = 0; s < 4; s++) slot_drive(s, pat(s + 1, 1'b0), 20);
        drive(4'hF, 8'hFF, 3);
        checks++; if (obs_q.size() - bf !== 1) begin errors++; $display("FAIL mid_pre_frame got %0d want 1", obs_q.size() - bf); end
        for (int s = 0; s < 3; s++) slot_drive(s, pat(s + 5, 1'b0), 20);
        reset = 1'b1;
        #1;
        checks++; if (bif.digits_out !== 16'h0000) begin errors++; $display("FAIL mid_async_digits got %h want 0000", bif.digits_out); end
        checks++; if (bif.frame_valid !== 1'b0 || bif.code_err !== 1'b0) begin errors++; $display("FAIL mid_async_pulses got %b%b want 00", bif.frame_valid, bif.code_err); end
        @(negedge clk);
        do_reset();
        bf = obs_q.size();
        slot_drive(3, pat(11, 1'b0), 20);
        drive(4'hF, 8'hFF, 3);
        checks++; if (obs_q.size() - bf !== 0) begin errors++; $display("FAIL mid_stale_mask got %0d want 0", obs_q.size() - bf); end
        for (int s = 0; s < 3; s++) slot_drive(s, pat(s + 8, 1'b0), 20);
        drive(4'hF, 8'hFF, 3);
        checks++; if (obs_q.size() - bf !== 1) begin errors++; $display("FAIL mid_post_frame got %0d want 1", obs_q.size() - bf); end
        else begin
            checks++; if (obs_q[bf][15:0] !== 16'hBA98) begin errors++; $display("FAIL mid_digits got %h want BA98", obs_q[bf][15:0]); end
        end
    endtask

    task automatic test_dp();
        int bf;
        logic [3:0] exp_dp;
`ifdef SSEG_DP_CAPTURE_EN
        exp_dp = 4'b1000;
`else
        exp_dp = 4'b0000;
`endif
        do_reset();
        bf = obs_q.size();
        for (int s = 0; s < 4; s++) slot_drive(s, pat(0, s == 3), 20);
        drive(4'hF, 8'hFF, 3);
        checks++; if (obs_q.size() - bf !== 1) begin errors++; $display("FAIL dp_frames got %0d want 1", obs_q.size() - bf); end
        else begin
            checks++; if (obs_q[bf][19:16] !== exp_dp) begin errors++; $display("FAIL dp_out got %b want %b", obs_q[bf][19:16], exp_dp); end
            checks++; if (obs_q[bf][15:0] !== 16'h0000) begin errors++; $display("FAIL dp_digits got %h want 0000", obs_q[bf][15:0]); end
        end
    endtask

    // Frame-level model: a one-cold segment held well past STABLE captures, one well short never does.
    task automatic test_random();
        int          bf, be, exp_err;
        logic [19:0] exp_q[$];
        logic [3:0]  m_mask;
        logic [3:0]  m_dig [4];
        logic [3:0]  m_dp;
        logic [3:0]  an, prev_an;
        logic [7:0]  ca, prev_ca;
        int          hold, slot, idx, zeros;
        bit          dp_on;
        do_reset();
        bf = obs_q.size(); be = err_total; exp_err = 0;
        m_mask = '0; m_dp = '0;
        for (int i = 0; i < 4; i++) m_dig[i] = '0;
        prev_an = 4'hF; prev_ca = 8'hFF;
        for (int seg = 0; seg < 80; seg++) begin
            do begin
                if ($urandom_range(0, 9) == 0) begin
                    do begin
                        an = 4'($urandom_range(0, 15));
                        zeros = 0;
                        for (int b = 0; b < 4; b++) if (!an[b]) zeros++;
                    end while (zeros == 1);
                    slot = -1;
                end else begin
                    slot = $urandom_range(0, 3);
                    an = ~(4'b0001 << slot);
                end
                dp_on = $urandom_range(0, 1) == 1;
                if ($urandom_range(0, 4) == 0) ca = {~dp_on, 7'($urandom_range(0, 127))};
                else ca = pat($urandom_range(0, 15), dp_on);
            end while (an == prev_an && ca[6:0] == prev_ca[6:0]);
            hold = ($urandom_range(0, 9) < 7) ? $urandom_range(STABLE + 2, STABLE + 6)
                                              : $urandom_range(2, STABLE - 3);
            drive(an, ca, hold);
            prev_an = an; prev_ca = ca;
            if (slot >= 0 && hold >= STABLE + 2) begin
                idx = -1;
                for (int d = 0; d < 16; d++) if (segtab[d] == ca[6:0]) idx = d;
                if (idx < 0) exp_err++;
                else begin
                    m_dig[slot] = 4'(idx);
`ifdef SSEG_DP_CAPTURE_EN
                    m_dp[slot] = ~ca[7];
`else
                    m_dp[slot] = 1'b0;
`endif
                    m_mask[slot] = 1'b1;
                    if (m_mask == 4'hF) begin
                        exp_q.push_back({m_dp, m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
                        m_mask = '0;
                    end
                end
            end
        end
        drive(4'hF, 8'hFF, 5);
        checks++; if (obs_q.size() - bf !== exp_q.size()) begin errors++; $display("FAIL rand_frame_count got %0d want %0d", obs_q.size() - bf, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && bf + i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[bf + i] !== exp_q[i]) begin errors++; $display("FAIL rand_frame%0d got %h want %h", i, obs_q[bf + i], exp_q[i]); end
        end
        checks++; if (err_total - be !== exp_err) begin errors++; $display("FAIL rand_code_err got %0d want %0d", err_total - be, exp_err); end
    endtask

    initial begin
        bif.anodes   = 4'hF;
        bif.cathodes = 8'hFF;
        test_reset();
        test_basic();
        test_short_slot();
        test_code_err();
        test_multi_anode();
        test_reset_mid();
        test_dp();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule
